// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module   : countdown_timer
//  Purpose  : Loadable, prescaled down-counter with one-shot or auto-reload
//             operation and a 1-cycle done pulse on each expiry.
//  Options  : COUNTDOWN_WRAP_CNT_EN adds an 8-bit saturating expiry counter.
//  Revision : 1.0 - initial release
// ============================================================================
module countdown_timer #(
    parameter int WIDTH    = 7,
    parameter int MAX_LOAD = 99,
    parameter int DIV      = 1
) (
    input  logic             i_clock,
    input  logic             i_reset_sync,
    input  logic             i_load_valid,
    input  logic [WIDTH-1:0] i_load_value,
    output logic             o_load_ready,
    input  logic             i_start,
    input  logic             i_pause,
    input  logic             i_abort,
    input  logic             i_mode_reload,
    output logic [WIDTH-1:0] o_value,
    output logic             o_busy,
    output logic             o_done,
`ifdef COUNTDOWN_WRAP_CNT_EN
    output logic [7:0]       o_wrap_count,
`endif
    output logic [1:0]       o_state
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0]    c_div_last = PW'(DIV - 1);
    localparam logic [PW-1:0]    c_pre_one  = PW'(1);
    localparam logic [WIDTH-1:0] c_max_load = WIDTH'(MAX_LOAD);
    localparam logic [WIDTH-1:0] c_val_one  = WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_RUN    = 2'd2,
        ST_PAUSED = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] load_q,  load_d;
    logic [PW-1:0]    pre_q,   pre_d;
    logic             mode_q,  mode_d;
    logic             done_q,  done_d;

    logic             w_load_ready;
    logic             w_load_accept;
    logic             w_tick;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_load_ready   = (state_q == ST_IDLE) || (state_q == ST_ARMED);
    assign w_load_accept  = i_load_valid && w_load_ready && !i_abort;
    assign w_tick         = (pre_q == c_div_last);
    assign w_load_clamped = (i_load_value > c_max_load) ? c_max_load : i_load_value;

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        load_d  = load_q;
        pre_d   = pre_q;
        mode_d  = mode_q;
        done_d  = 1'b0;

        if (i_abort) begin
            state_d = ST_IDLE;
            value_d = '0;
            pre_d   = '0;
        end else if (w_load_accept) begin
            value_d = w_load_clamped;
            load_d  = w_load_clamped;
            state_d = (w_load_clamped != '0) ? ST_ARMED : ST_IDLE;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (i_start) begin
                        state_d = ST_RUN;
                        pre_d   = '0;
                        mode_d  = i_mode_reload;
                    end
                end
                ST_RUN: begin
                    // A pause request wins over a coincident tick.
                    if (i_pause) begin
                        state_d = ST_PAUSED;
                    end else if (w_tick) begin
                        pre_d = '0;
                        if (value_q > c_val_one) begin
                            value_d = value_q - c_val_one;
                        end else if (value_q == c_val_one) begin
                            value_d = '0;
                            done_d  = 1'b1;
                            if (!mode_q) begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            // Zero is only held in RUN by reload mode.
                            value_d = load_q;
                        end
                    end else begin
                        pre_d = pre_q + c_pre_one;
                    end
                end
                ST_PAUSED: begin
                    if (!i_pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset_sync) begin
            state_q <= ST_IDLE;
            value_q <= '0;
            load_q  <= '0;
            pre_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            load_q  <= load_d;
            pre_q   <= pre_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

`ifdef COUNTDOWN_WRAP_CNT_EN
    logic [7:0] wrap_q, wrap_d;

    always_comb begin
        wrap_d = wrap_q;
        if (w_load_accept) begin
            wrap_d = '0;
        end else if (done_d && (wrap_q != 8'hFF)) begin
            wrap_d = wrap_q + 8'd1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset_sync) begin
            wrap_q <= '0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign o_wrap_count = wrap_q;
`endif

    assign o_load_ready = w_load_ready;
    assign o_value      = value_q;
    assign o_busy       = (state_q == ST_RUN) || (state_q == ST_PAUSED);
    assign o_done       = done_q;
    assign o_state      = state_q;

endmodule
`default_nettype wire
